// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared definitions for the FIFO-fronted UART transmitter.
//   tx_state_t : transmit FSM states. PARITY exists only when UART_TX_PARITY_EN
//                is defined.
//   baud_div   : rounded clock-per-bit divisor, (clk_freq + baud/2) / baud.
//   IDLE_LEVEL : level of the serial line when nothing is being sent.
// Optional feature macro: UART_TX_PARITY_EN.
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Write-port bundle between the bus/CPU side and the transmitter.
//   TxD_start : write strobe (master -> slave)
//   TxD_data  : word to queue (master -> slave)
//   TxD_ready : FIFO not full, a strobe is accepted only while high (slave -> master)
interface uart_tx_fifo_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 TxD_start;
  logic [DATA_BITS-1:0] TxD_data;
  logic                 TxD_ready;

  modport master (output TxD_start, output TxD_data, input TxD_ready);
  modport slave  (input TxD_start, input TxD_data, output TxD_ready);
endinterface

// File: rtl/uart_tx_fifo_param_fifo.sv
// uart_sync_fifo: small single-clock FIFO that queues words for the transmitter.
//   clk, rst_n : clock, synchronous active-low reset (flushes the FIFO)
//   push, din  : write request and data, ignored while full
//   pop, dout  : read request, dout shows the head word
//   count      : number of stored words
//   full/empty : status flags
// The head word is read combinationally so the FSM can load it on the same
// edge that pops it. DEPTH must be a power of two so the pointers wrap freely.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg;
  logic             do_push, do_pop;

  // A push is refused when full even if a pop happens in the same cycle.
  assign do_push = push && !full_reg;
  assign do_pop  = pop && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_W);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = full_reg;
  assign empty = (count_reg == '0);
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: parametrised UART transmitter with a write FIFO.
//   clk, rst_n : system clock, synchronous active-low reset
//   wr         : write port (TxD_start / TxD_data / TxD_ready), slave side
//   TxD        : serial line, idle high, always driven from a register
//   TxD_busy   : frame on the line or words still queued
//   fifo_count : queued words, not counting the frame in flight
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits; every bit lasts DIV clocks.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit,
// even parity, or odd when PARITY_ODD=1).
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_fifo_param_if.slave           wr,
  output logic                          TxD,
  output logic                          TxD_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  // Reject unsupported configurations at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      DIV < 2) begin : g_bad_param
    $error("uart_tx_fifo_param: unsupported parameter set");
  end

  tx_state_t            state_reg, state_next;
  logic [CW-1:0]        baud_reg, baud_next;
  logic [3:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 txd_reg, busy_reg;
  logic                 line_level, pop, bit_end;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg, parity_next;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr.TxD_start),
    .pop   (pop),
    .din   (wr.TxD_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr.TxD_ready = !fifo_full;
  assign bit_end      = (baud_reg == DIV_LAST);

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    pop          = 1'b0;
    line_level   = IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          parity_next = (^fifo_dout) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        line_level = 1'b0;
        if (bit_end) begin
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        line_level = shift_reg[0];
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == DATA_LAST) begin
            bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_level = parity_reg;
        if (bit_end) begin
          baud_next  = '0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        line_level = 1'b1;
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx_reg == STOP_LAST) begin
            bit_idx_next = '0;
            // Chain straight into the next frame when more words are queued.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_dout;
              state_next = START;
`ifdef UART_TX_PARITY_EN
              parity_next = (^fifo_dout) ^ (PARITY_ODD != 0);
`endif
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // TxD and TxD_busy are both registered from the current state, so busy
  // stays aligned with the line and drops exactly when the last stop bit ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= IDLE_LEVEL;
      busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      txd_reg     <= line_level;
      busy_reg    <= (state_reg != IDLE) || !fifo_empty;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign TxD      = txd_reg;
  assign TxD_busy = busy_reg;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: instance A at default parameters (DIV=434),
// instance B fast (DIV=10) with DATA_BITS=7, STOP_BITS=2, PARITY_ODD=1.
// Every TxD value is logged per cycle and compared against frames built from
// the word, bit by bit, with exact bit timing.
module tb_uart_tx_fifo_param;
`ifdef UART_TX_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  localparam int DIV_A = 434;
  localparam int DIV_B = 10;
  localparam int LEN_A = (1 + 8 + 1 + PE) * DIV_A;
  localparam int LEN_B = (1 + 7 + 2 + PE) * DIV_B;

  typedef logic bitq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd_a, busy_a, txd_b, busy_b;
  logic [2:0] cnt_a, cnt_b;

  uart_tx_fifo_param_if #(.DATA_BITS(8)) ifa ();
  uart_tx_fifo_param_if #(.DATA_BITS(7)) ifb ();

  uart_tx_fifo_param dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (ifa.slave),
    .TxD        (txd_a),
    .TxD_busy   (busy_a),
    .fifo_count (cnt_a)
  );

  uart_tx_fifo_param #(
    .CLK_FREQ   (1000000),
    .BAUD       (100000),
    .DATA_BITS  (7),
    .STOP_BITS  (2),
    .FIFO_DEPTH (4),
    .PARITY_ODD (1)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (ifb.slave),
    .TxD        (txd_b),
    .TxD_busy   (busy_b),
    .fifo_count (cnt_b)
  );

  always #5 clk = ~clk;

  // Per-cycle history; index k holds the value after the k-th rising edge.
  logic       ha[$], hb[$], hba[$];
  logic [2:0] hca[$];
  always @(negedge clk) begin
    ha.push_back(txd_a);
    hb.push_back(txd_b);
    hba.push_back(busy_a);
    hca.push_back(cnt_a);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line bits of one frame: start, data LSB first, optional parity, stops.
  function automatic bitq_t frame_bits(input int w, input int dbits, input int sbits,
                                       input bit odd);
    bitq_t q;
    bit    p;
    p = odd;
    q.push_back(1'b0);
    for (int i = 0; i < dbits; i++) begin
      q.push_back(w[i]);
      p ^= w[i];
    end
    if (PE) q.push_back(p);
    for (int i = 0; i < sbits; i++) q.push_back(1'b1);
    return q;
  endfunction

  function automatic logic hist(input bit sel, input int i);
    if (sel) return (i < hb.size()) ? hb[i] : 1'bx;
    return (i < ha.size()) ? ha[i] : 1'bx;
  endfunction

  // Number of cycles where the line differs from the expected bit sequence.
  function automatic int line_err(input bit sel, input int s, input bitq_t bits, input int div);
    int e = 0;
    for (int k = 0; k < bits.size(); k++)
      for (int c = 0; c < div; c++)
        if (hist(sel, s + k * div + c) !== bits[k]) e++;
    return e;
  endfunction

  function automatic int zeros(input bit sel, input int from, input int n);
    int e = 0;
    for (int i = from; i < from + n; i++)
      if (hist(sel, i) !== 1'b1) e++;
    return e;
  endfunction

  initial begin
    int    m, s, s2, k, w, mr;
    bitq_t q;

    ifa.TxD_start = 1'b0;
    ifa.TxD_data  = '0;
    ifb.TxD_start = 1'b0;
    ifb.TxD_data  = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    chk("a_rst_txd", txd_a, 1);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_ready", ifa.TxD_ready, 1);
    chk("a_rst_count", cnt_a, 0);
    chk("b_rst_txd", txd_b, 1);
    chk("b_rst_ready", ifb.TxD_ready, 1);
    tick();

    // Single word 0x2F into idle A.
    ifa.TxD_start = 1'b1;
    ifa.TxD_data  = 8'h2F;
    tick();
    ifa.TxD_start = 1'b0;
    m = ha.size();
    repeat (LEN_A + 20) tick();
    s = m + 2;
    chk("a_latency_high", ha[m + 1], 1);
    chk("a_latency_low", ha[s], 0);
    chk("a_frame_2F", line_err(0, s, frame_bits(8'h2F, 8, 1, 1'b0), DIV_A), 0);
    chk("a_busy_last", hba[s + LEN_A - 1], 1);
    chk("a_busy_fall", hba[s + LEN_A], 0);
    chk("a_line_after", ha[s + LEN_A], 1);

    // Back-to-back 0x2F then 0xAA.
    ifa.TxD_start = 1'b1;
    ifa.TxD_data  = 8'h2F;
    tick();
    m = ha.size();
    ifa.TxD_data  = 8'hAA;
    tick();
    ifa.TxD_start = 1'b0;
    chk("a_count_pushpop", cnt_a, 1);
    repeat (2 * LEN_A + 20) tick();
    s  = m + 2;
    s2 = s + LEN_A;
    chk("a_b2b_frame1", line_err(0, s, frame_bits(8'h2F, 8, 1, 1'b0), DIV_A), 0);
    chk("a_b2b_frame2", line_err(0, s2, frame_bits(8'hAA, 8, 1, 1'b0), DIV_A), 0);
    chk("a_b2b_count_before_pop", hca[s2 - 2], 1);
    chk("a_b2b_count_at_pop", hca[s2 - 1], 0);
    chk("a_b2b_line_after", ha[s2 + LEN_A], 1);

    // Reset in the middle of the data bits of 0x55.
    ifa.TxD_start = 1'b1;
    ifa.TxD_data  = 8'h55;
    tick();
    ifa.TxD_start = 1'b0;
    repeat (2 + 3 * DIV_A + DIV_A / 2) tick();
    chk("a_busy_prereset", busy_a, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mr = ha.size();
    chk("a_midrst_txd", txd_a, 1);
    chk("a_midrst_busy", busy_a, 0);
    chk("a_midrst_count", cnt_a, 0);
    repeat (LEN_A) tick();
    chk("a_midrst_no_low", zeros(0, mr, LEN_A), 0);

    // B: 7 data bits, 2 stop bits, word 0x7F.
    ifb.TxD_start = 1'b1;
    ifb.TxD_data  = 7'h7F;
    tick();
    ifb.TxD_start = 1'b0;
    m = hb.size();
    repeat (LEN_B + 20) tick();
    chk("b_7F_latency", hb[m + 1], 1);
    chk("b_frame_7F", line_err(1, m + 2, frame_bits(7'h7F, 7, 2, 1'b1), DIV_B), 0);
    chk("b_7F_line_after", hb[m + 2 + LEN_B], 1);

    // B: six consecutive strobes into a depth-4 FIFO; the sixth is dropped.
    q = {};
    ifb.TxD_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ifb.TxD_data = 7'(i + 1);
      tick();
      if (i == 0) m = hb.size();
      chk($sformatf("b_ovf_ready_%0d", i), ifb.TxD_ready, (i < 4) ? 1 : 0);
      chk($sformatf("b_ovf_count_%0d", i), cnt_b, (i == 0) ? 1 : ((i < 4) ? i : 4));
      if (i < 5) q = {q, frame_bits(i + 1, 7, 2, 1'b1)};
    end
    ifb.TxD_start = 1'b0;
    repeat (6 * LEN_B) tick();
    chk("b_ovf_frames", line_err(1, m + 2, q, DIV_B), 0);
    chk("b_ovf_no_sixth", zeros(1, m + 2 + 5 * LEN_B, LEN_B - 10), 0);
    chk("b_ovf_count_end", cnt_b, 0);

    // B: random bursts of 1..3 words from idle.
    for (int b = 0; b < 8; b++) begin
      k = $urandom_range(1, 3);
      repeat ($urandom_range(0, 15)) tick();
      q = {};
      ifb.TxD_start = 1'b1;
      for (int j = 0; j < k; j++) begin
        w = $urandom_range(0, 127);
        ifb.TxD_data = 7'(w);
        tick();
        if (j == 0) m = hb.size();
        chk($sformatf("b_rnd%0d_count_%0d", b, j), cnt_b, (j == 0) ? 1 : j);
        q = {q, frame_bits(w, 7, 2, 1'b1)};
      end
      ifb.TxD_start = 1'b0;
      repeat (k * LEN_B + 20) tick();
      chk($sformatf("b_rnd%0d_frames", b), line_err(1, m + 2, q, DIV_B), 0);
      chk($sformatf("b_rnd%0d_idle_after", b), zeros(1, m + 2 + k * LEN_B, 10), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
- Parametrised successor to the fixed-format async transmitter.
- Serialises words onto the TxD line with configurable data width, stop-bit count and baud rate.
- A small synchronous FIFO in front lets firmware queue frames back-to-back without polling TxD_busy.
- Sits between the soft-CPU/bus write port and the board UART pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Divisor DIV = (CLK_FREQ + BAUD/2) / BAUD, which is 434 at defaults.
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 4, queued words; power of two, 2..16.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- TxD_start  in  1  write strobe; pushes TxD_data when TxD_ready=1.
- TxD_data  in  DATA_BITS  word to transmit.
- TxD  out  1  serial line, idle high.
- TxD_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- TxD_ready  out  1  FIFO not full; a write is accepted only when this is high.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued, excluding the frame in flight.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - TxD=1, TxD_busy=0, TxD_ready=1, fifo_count=0.
  - FIFO flushed, FSM to IDLE, baud counter cleared.
  - Reset mid-frame aborts the frame; TxD is 1 after that edge.
- Push rule:
  - A push happens on an edge with TxD_start=1 and TxD_ready=1.
  - TxD_start while TxD_ready=0 is dropped silently; no state change.
  - TxD_start held high for several cycles pushes once per cycle while ready.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - If fifo_count>0: pop the head into the shift register, clear the baud counter, go to START.
  - Latency: a write into an empty, idle block drives TxD low 2 clocks after the push edge.
- Bit timing: each bit holds for exactly DIV clocks (baud counter 0..DIV-1). State advances when the counter reaches DIV-1.
- START: TxD=0.
- DATA: TxD = shift_reg[0], LSB first; shift right each bit; DATA_BITS bits.
- STOP:
  - TxD=1 for STOP_BITS bit periods.
  - At the end, if fifo_count>0, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Simultaneous push and pop in the same cycle: fifo_count unchanged and both take effect. A push is still refused when count==FIFO_DEPTH, even if a pop occurs that cycle.
- TxD_ready = (fifo_count != FIFO_DEPTH), registered with the count.
- TxD_busy = (state != IDLE) || (fifo_count != 0).
- TxD is driven from a register, never combinationally from the FSM.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP for one bit period.
  - Bit value = XOR of the data bits, inverted when PARITY_ODD=1.
  - Frame length = 2 + DATA_BITS + STOP_BITS bit periods.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame length = 1 + DATA_BITS + STOP_BITS; PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (tx_state_t);
  - the function baud_div(CLK_FREQ, BAUD);
  - constant IDLE_LEVEL=1'b1.
- One sub-module: uart_sync_fifo, a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/din/dout/count/full/empty, and the same clock and reset. The FSM and baud counter stay in the top level.

Test Plan:
- Reset mid-frame, and FIFO overflow:
  - Assert rst_n=0 for 1 clock during DATA of 0x55 -> next edge TxD=1, TxD_busy=0, fifo_count=0, no further low bits.
  - Pulse TxD_start 6 consecutive clocks with 0x01..0x06 (DEPTH=4, idle) -> 0x01 pops immediately and 0x02..0x05 are queued, so TxD_ready=0 from the cycle after the fifth push.
  - 0x06 is dropped; exactly 5 frames appear.
- Defaults, one write of 0x2F into an idle block -> TxD goes low 2 clocks later.
  - Line sequence 0,1,1,1,1,0,1,0,0,1, each held 434 clocks.
  - TxD_busy falls 4340 clocks after TxD fell.
- Back-to-back writes 0x2F then 0xAA while busy -> second start bit begins the cycle immediately after the first stop bit ends; fifo_count goes 1->0 at that pop.
- STOP_BITS=2, DATA_BITS=7, write 0x7F -> frame is 0, seven 1s, 1, 1; total 10 bit periods; line high after.
- UART_TX_PARITY_EN defined, PARITY_ODD=0:
  - Write 0x2F -> parity bit 1 after the data bits; frame 11 bits.
  - With PARITY_ODD=1, same word -> parity bit 0.
